// File: rtl/sipo_rr_arbiter_if.sv
// Handshake bundle between serial requesters, the packing arbiter
// and the wide downstream consumer.
interface sipo_rr_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_NUM = 2,
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH*MAX_NUM-1:0] out_data;
  logic [IDW-1:0]           out_id;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_data, out_id, out_valid, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_data, out_id, out_valid, busy
  );
endinterface

// File: rtl/sipo_rr_arbiter.sv
// Round-robin arbiter feeding one shared serial-to-parallel packer;
// grant is locked for a full burst, word leaves on valid/ready.
module sipo_rr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int MAX_NUM = 2,
  parameter int NUM_REQ = 4
) (
  input  logic clk,
  input  logic rst,
  sipo_rr_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(MAX_NUM + 1);
  localparam int PW  = WIDTH * MAX_NUM;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OUTPUT
  } state_t;

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     grant;
  logic [IDW-1:0]     pick;
  logic               found;
  logic [CW-1:0]      count;
  logic [CW-1:0]      cnt_nxt;
  logic [PW-1:0]      pack;
  logic [PW-1:0]      nxt_pack;
  logic [PW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               out_valid;
  logic               busy;
  logic [NUM_REQ-1:0] ready;
  logic [WIDTH-1:0]   beat;
  logic               take;
  int                 idx;

  // first valid requester at or above ptr, wrapping at NUM_REQ
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state == COLLECT)
      ready[grant] = 1'b1;
  end

  assign beat    = bus.req_data[int'(grant)*WIDTH +: WIDTH];
  assign take    = (state == COLLECT) && bus.req_valid[grant];
  assign cnt_nxt = count + CW'(1);

  generate
    if (MAX_NUM == 1) begin : g_one
      assign nxt_pack = beat;
    end else begin : g_shift
      assign nxt_pack = {beat, pack[PW-1:WIDTH]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      count     <= '0;
      pack      <= '0;
      out_data  <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            count <= '0;
            busy  <= 1'b1;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (take) begin
            pack  <= nxt_pack;
            count <= cnt_nxt;
            if (cnt_nxt == CW'(MAX_NUM)) begin
              out_data  <= nxt_pack;
              out_id    <= grant;
              out_valid <= 1'b1;
              state     <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
            ptr       <= (int'(grant) == NUM_REQ - 1) ? '0
                                                      : grant + IDW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_data  = out_data;
  assign bus.out_id    = out_id;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_sipo_rr_arbiter.sv
// Bench for sipo_rr_arbiter: directed bursts plus random traffic
// checked every cycle against a transaction-level model.
module tb_sipo_rr_arbiter;
  localparam int W  = 8;
  localparam int M  = 2;
  localparam int N  = 4;
  localparam int PW = W * M;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic           out_ready = 1'b0;

  sipo_rr_arbiter_if #(.WIDTH(W), .MAX_NUM(M), .NUM_REQ(N)) bus ();
  assign bus.req_valid = req_valid;
  assign bus.req_data  = req_data;
  assign bus.out_ready = out_ready;

  sipo_rr_arbiter #(.WIDTH(W), .MAX_NUM(M), .NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sipo_rr_arbiter_if #(.WIDTH(W), .MAX_NUM(M), .NUM_REQ(3)) bus3 ();
  assign bus3.req_valid = 3'b101;
  assign bus3.req_data  = 24'h5a00a5;
  assign bus3.out_ready = 1'b1;

  sipo_rr_arbiter #(.WIDTH(W), .MAX_NUM(M), .NUM_REQ(3)) u3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 collecting, 2 word waiting downstream
  int             m_ph = 0;
  int             m_ptr = 0;
  int             m_grant = 0;
  int             m_id = 0;
  logic [PW-1:0]  m_word = '0;
  logic [W-1:0]   m_beats[$];
  int             log_id[$];
  logic [PW-1:0]  log_word[$];

  task automatic model_step();
    if (rst) begin
      m_ph = 0; m_ptr = 0; m_grant = 0; m_id = 0; m_word = '0;
      m_beats.delete();
      return;
    end
    case (m_ph)
      0: begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (req_valid[i]) begin
            m_grant = i;
            m_beats.delete();
            m_ph = 1;
            break;
          end
        end
      end
      1: begin
        if (req_valid[m_grant]) begin
          m_beats.push_back(req_data[m_grant*W +: W]);
          if (m_beats.size() == M) begin
            m_word = '0;
            foreach (m_beats[j]) m_word |= PW'(m_beats[j]) << (W * j);
            m_id = m_grant;
            m_ph = 2;
          end
        end
      end
      default: begin
        if (out_ready) begin
          log_id.push_back(m_id);
          log_word.push_back(m_word);
          m_ph = 0;
          m_ptr = (m_grant + 1) % N;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  logic [N-1:0] exp_ready;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_ready = (m_ph == 1) ? N'(1) << m_grant : '0;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(m_ph == 2));
      chk("busy", 64'(bus.busy), 64'(m_ph != 0));
      chk("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'(1));
      if (m_ph == 2) begin
        chk("out_data", 64'(bus.out_data), 64'(m_word));
        chk("out_id", 64'(bus.out_id), 64'(m_id));
      end
    end
  end

  int ids3[$];
  initial begin
    forever begin
      @(negedge clk);
      if (!rst3 && bus3.out_valid) ids3.push_back(int'(bus3.out_id));
    end
  end

  task automatic send_beat(int id, logic [W-1:0] b);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    req_valid[id] = 1'b1;
    req_data[id*W +: W] = b;
    while (!acc && n < 100) begin
      acc = bus.req_ready[id];
      tick();
      n++;
    end
    req_valid[id] = 1'b0;
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_log(int target);
    int n;
    n = 0;
    while (log_id.size() < target && n < 300) begin
      tick();
      n++;
    end
    chk("wait_log_timeout", 64'(log_id.size() >= target), 64'(1));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int exp3[4]   = '{0, 2, 0, 2};
  int base;

  initial begin
    tick();
    rst  = 1'b0;
    rst3 = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_id", 64'(bus.out_id), 64'(0));

    // single requester, no gaps: 4 edges from req_valid to valid drop
    out_ready = 1'b1;
    req_valid = 4'b0001;
    req_data[7:0] = 8'h11;
    tick();
    tick();
    req_data[7:0] = 8'h22;
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", 64'(bus.out_valid), 64'(1));
    chk("single_data", 64'(bus.out_data), 64'h2211);
    chk("single_id", 64'(bus.out_id), 64'(0));
    tick();
    @(negedge clk);
    chk("single_valid_drop", 64'(bus.out_valid), 64'(0));
    chk("single_busy_drop", 64'(bus.busy), 64'(0));

    // backpressure with all requesters pushing
    out_ready = 1'b0;
    send_beat(1, 8'h33);
    send_beat(1, 8'h44);
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_data", 64'(bus.out_data), 64'h4433);
      chk("bp_id", 64'(bus.out_id), 64'(1));
      chk("bp_ready", 64'(bus.req_ready), 64'(0));
      tick();
    end
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_release", 64'(bus.out_valid), 64'(0));
    chk("bp_log", 64'(log_word[log_word.size()-1]), 64'h4433);

    // gapped burst on requester 2 while requester 3 waits
    send_beat(2, 8'hAB);
    req_valid[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("gap_grant", 64'(bus.req_ready), 64'b0100);
      tick();
    end
    req_valid[3] = 1'b0;
    send_beat(2, 8'hCD);
    @(negedge clk);
    chk("gap_data", 64'(bus.out_data), 64'hCDAB);
    chk("gap_id", 64'(bus.out_id), 64'(2));
    tick();

    // reset in the middle of a burst discards the partial word
    send_beat(1, 8'h55);
    pulse_rst();
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
    chk("mid_rst_data", 64'(bus.out_data), 64'(0));
    send_beat(1, 8'h66);
    send_beat(1, 8'h77);
    @(negedge clk);
    chk("post_rst_data", 64'(bus.out_data), 64'h7766);
    chk("post_rst_id", 64'(bus.out_id), 64'(1));
    tick();

    // all requesters busy: strict rotation from ptr 0
    pulse_rst();
    req_valid = '1;
    req_data  = 32'hD4C3B2A1;
    base = log_id.size();
    wait_log(base + 6);
    req_valid = '0;
    if (log_id.size() >= base + 6)
      for (int k = 0; k < 6; k++)
        chk("rr_id", 64'(log_id[base+k]), 64'(exp_rr[k]));

    // random traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      req_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    chk("nr3_count", 64'(ids3.size() >= 4), 64'(1));
    if (ids3.size() >= 4)
      for (int k = 0; k < 4; k++)
        chk("nr3_id", 64'(ids3[k]), 64'(exp3[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
